// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types and default sizing for the ICG enable controller.
package clk_gate_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_WAKE = 2'd1,
      ST_ON   = 2'd2,
      ST_IDLE = 2'd3
   } dom_state_t;

   localparam int DEF_N_DOM    = 4;
   localparam int DEF_IDLE_W   = 8;
   localparam int DEF_WAKE_CYC = 2;
   // Wake counter width covers the full 1..15 WAKE_CYC range.
   localparam int WCNT_W       = 4;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/clk_gate_rr_pick.sv
// Combinational round-robin one-hot picker; search starts just after last.
module clk_gate_rr_pick #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     cand,
   input  logic [IDX_W-1:0] last,
   output logic [N-1:0]     grant,
   output logic             valid
);

   logic [IDX_W-1:0] pos;

   always_comb begin
      grant = '0;
      valid = 1'b0;
      pos   = '0;
      for (int i = 1; i <= N; i++) begin
         pos = IDX_W'((int'(last) + i) % N);
         if (!valid && cand[pos]) begin
            grant[pos] = 1'b1;
            valid      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/clk_gate_ctrl.sv
// Per-domain ICG enable sequencer (OFF/WAKE/ON/IDLE) with one-at-a-time
// round-robin wake arbitration and scan/force overrides.
module clk_gate_ctrl
   import clk_gate_ctrl_pkg::*;
#(
   parameter int N_DOM    = DEF_N_DOM,
   parameter int IDLE_W   = DEF_IDLE_W,
   parameter int WAKE_CYC = DEF_WAKE_CYC
) (
   input  logic              CK,
   input  logic              RST,
   input  logic [N_DOM-1:0]  req,
   input  logic [N_DOM-1:0]  busy,
   input  logic [IDLE_W-1:0] idle_thresh,
   input  logic [N_DOM-1:0]  force_on,
   input  logic              test_mode,
   output logic [N_DOM-1:0]  en,
   output logic [N_DOM-1:0]  se,
   output logic [N_DOM-1:0]  ack,
   output logic [N_DOM-1:0]  gated
);

   localparam int IDX_W = idx_width(N_DOM);

   logic [N_DOM-1:0] cand;
   logic [N_DOM-1:0] wake_hold;
   logic [N_DOM-1:0] pick_grant;
   logic             pick_valid;
   logic [N_DOM-1:0] grant;
   logic             grant_any;
   logic [IDX_W-1:0] grant_idx;
   logic [IDX_W-1:0] last_grant;
   logic [N_DOM-1:0] en_q;
   logic [N_DOM-1:0] ack_q;
   logic [N_DOM-1:0] gated_q;

   clk_gate_rr_pick #(
      .N     (N_DOM),
      .IDX_W (IDX_W)
   ) u_pick (
      .cand  (cand),
      .last  (last_grant),
      .grant (pick_grant),
      .valid (pick_valid)
   );

   // A domain on its final WAKE cycle hands over the wake slot on the same
   // edge, so back-to-back wakes are spaced exactly WAKE_CYC apart.
   assign grant_any = pick_valid && !(|wake_hold);
   assign grant     = grant_any ? pick_grant : '0;

   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < N_DOM; i++) begin
         if (grant[i]) grant_idx = IDX_W'(i);
      end
   end

   always_ff @(posedge CK) begin
      if (RST) begin
         last_grant <= IDX_W'(N_DOM - 1);
      end else if (grant_any) begin
         last_grant <= grant_idx;
      end
   end

   for (genvar d = 0; d < N_DOM; d++) begin : g_dom
      dom_state_t        st, st_nxt;
      logic [WCNT_W-1:0] wcnt, wcnt_nxt;
      logic [IDLE_W-1:0] icnt, icnt_nxt;
      logic              en_r, ack_r, gated_r;

      assign cand[d]      = (st == ST_OFF) && req[d];
      assign wake_hold[d] = (st == ST_WAKE) && (wcnt != '0);
      assign en_q[d]      = en_r;
      assign ack_q[d]     = ack_r;
      assign gated_q[d]   = gated_r;

      always_comb begin
         st_nxt   = st;
         wcnt_nxt = wcnt;
         icnt_nxt = icnt;
         case (st)
            ST_OFF: begin
               if (grant[d]) begin
                  st_nxt   = ST_WAKE;
                  wcnt_nxt = WCNT_W'(WAKE_CYC - 1);
               end
            end
            ST_WAKE: begin
               if (wcnt == '0) st_nxt = ST_ON;
               else            wcnt_nxt = wcnt - 1'b1;
            end
            ST_ON: begin
               if (!req[d] && !busy[d]) begin
                  st_nxt   = ST_IDLE;
                  icnt_nxt = idle_thresh;
               end
            end
            ST_IDLE: begin
               // Clock never stopped here, so activity returns straight to ON.
               if (req[d] || busy[d]) st_nxt = ST_ON;
               else if (icnt == '0)   st_nxt = ST_OFF;
               else                   icnt_nxt = icnt - 1'b1;
            end
            default: st_nxt = ST_OFF;
         endcase
      end

      always_ff @(posedge CK) begin
         if (RST) begin
            st      <= ST_OFF;
            wcnt    <= '0;
            icnt    <= '0;
            en_r    <= 1'b0;
            ack_r   <= 1'b0;
            gated_r <= 1'b1;
         end else begin
            st      <= st_nxt;
            wcnt    <= wcnt_nxt;
            icnt    <= icnt_nxt;
            en_r    <= (st_nxt != ST_OFF);
            ack_r   <= (st_nxt == ST_ON);
            gated_r <= (st_nxt == ST_OFF);
         end
      end
   end

   assign en    = en_q | force_on;
   assign se    = {N_DOM{test_mode}};
   assign ack   = ack_q;
   assign gated = gated_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed scoreboard bench for clk_gate_ctrl (N_DOM=4, WAKE_CYC=2).
module tb_clk_gate_ctrl;

   localparam int SIG_EN    = 0;
   localparam int SIG_ACK   = 1;
   localparam int SIG_GATED = 2;
   localparam int SIG_SE    = 3;

   logic       CK = 1'b0;
   logic       RST;
   logic [3:0] req, busy, force_on, en, se, ack, gated;
   logic [7:0] idle_thresh;
   logic       test_mode;

   typedef struct {
      string      tag;
      int         sig;
      logic [3:0] mask;
      logic [3:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   clk_gate_ctrl #(.N_DOM(4), .IDLE_W(8), .WAKE_CYC(2)) dut (
      .CK          (CK),
      .RST         (RST),
      .req         (req),
      .busy        (busy),
      .idle_thresh (idle_thresh),
      .force_on    (force_on),
      .test_mode   (test_mode),
      .en          (en),
      .se          (se),
      .ack         (ack),
      .gated       (gated)
   );

   always #5 CK = ~CK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [3:0] get_sig(input int s);
      case (s)
         SIG_EN:    return en;
         SIG_ACK:   return ack;
         SIG_GATED: return gated;
         default:   return se;
      endcase
   endfunction

   task automatic push(input string tag, input int sig, input logic [3:0] mask,
                       input logic [3:0] val);
      exp_t e;
      e.tag = tag; e.sig = sig; e.mask = mask; e.val = val;
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t       e;
      logic [3:0] obs;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = get_sig(e.sig) & e.mask;
         n_assert++;
         assert (obs === (e.val & e.mask)) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b (mask %b)", e.tag, obs,
                   e.val & e.mask, e.mask);
         end
      end
   endtask

   task automatic step();
      @(posedge CK);
      #1;
      drain();
   endtask

   logic [3:0] c_en    [1:9] = '{4'b0001, 4'b0001, 4'b0011, 4'b0011, 4'b0111,
                                 4'b0111, 4'b1111, 4'b1111, 4'b1111};
   logic [3:0] c_ack   [1:9] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0011,
                                 4'b0011, 4'b0111, 4'b0111, 4'b1111};
   logic [3:0] c_gated [1:9] = '{4'b1110, 4'b1110, 4'b1100, 4'b1100, 4'b1000,
                                 4'b1000, 4'b0000, 4'b0000, 4'b0000};

   initial begin
      RST = 1'b1; req = '0; busy = '0; force_on = '0; test_mode = 1'b0;
      idle_thresh = 8'd2;

      // Reset state
      step();
      push("rst_en", SIG_EN, 4'hF, 4'h0);
      push("rst_ack", SIG_ACK, 4'hF, 4'h0);
      push("rst_gated", SIG_GATED, 4'hF, 4'hF);
      push("rst_se", SIG_SE, 4'hF, 4'h0);
      step();

      // Single wake: req[0] in cycle 0
      RST = 1'b0; req = 4'b0001;
      push("w1_en", SIG_EN, 4'b0001, 4'b0001);
      push("w1_ack", SIG_ACK, 4'b0001, 4'b0000);
      push("w1_gated", SIG_GATED, 4'b0001, 4'b0000);
      step();
      push("w2_en", SIG_EN, 4'b0001, 4'b0001);
      push("w2_ack", SIG_ACK, 4'b0001, 4'b0000);
      step();
      push("w3_en", SIG_EN, 4'hF, 4'b0001);
      push("w3_ack", SIG_ACK, 4'hF, 4'b0001);
      step();

      // Release with idle_thresh=2: en low at t+4
      req = 4'b0000;
      for (int k = 1; k <= 4; k++) begin
         push($sformatf("rel_en_t%0d", k), SIG_EN, 4'b0001, (k < 4) ? 4'b0001 : 4'b0000);
         push($sformatf("rel_ack_t%0d", k), SIG_ACK, 4'b0001, 4'b0000);
         push($sformatf("rel_gated_t%0d", k), SIG_GATED, 4'b0001, (k == 4) ? 4'b0001 : 4'b0000);
         step();
      end

      // Contention from reset: order 0,1,2,3
      RST = 1'b1;
      step();
      RST = 1'b0; req = 4'b1111;
      for (int k = 1; k <= 9; k++) begin
         push($sformatf("cont_en_c%0d", k), SIG_EN, 4'hF, c_en[k]);
         push($sformatf("cont_ack_c%0d", k), SIG_ACK, 4'hF, c_ack[k]);
         push($sformatf("cont_gated_c%0d", k), SIG_GATED, 4'hF, c_gated[k]);
         step();
      end

      // Hysteresis idle_thresh=5 on domain 3: en low at t+7
      idle_thresh = 8'd5; req = 4'b0111;
      for (int k = 1; k <= 7; k++) begin
         push($sformatf("hys_en3_t%0d", k), SIG_EN, 4'b1000, (k < 7) ? 4'b1000 : 4'b0000);
         push($sformatf("hys_ack3_t%0d", k), SIG_ACK, 4'b1000, 4'b0000);
         step();
      end

      // Re-assert domain 2 at t+4: ack at t+5, en never drops
      req = 4'b0011;
      for (int k = 1; k <= 4; k++) begin
         push($sformatf("rea_en2_t%0d", k), SIG_EN, 4'b0100, 4'b0100);
         push($sformatf("rea_ack2_t%0d", k), SIG_ACK, 4'b0100, 4'b0000);
         step();
      end
      req = 4'b0111;
      push("rea_en2_t5", SIG_EN, 4'b0100, 4'b0100);
      push("rea_ack2_t5", SIG_ACK, 4'b0100, 4'b0100);
      step();

      // Busy hold on domain 1 for 20 cycles, then release
      req = 4'b0101; busy = 4'b0010;
      for (int k = 1; k <= 20; k++) begin
         push($sformatf("busy_en1_c%0d", k), SIG_EN, 4'b0010, 4'b0010);
         push($sformatf("busy_gated1_c%0d", k), SIG_GATED, 4'b0010, 4'b0000);
         step();
      end
      busy = 4'b0000;
      for (int k = 1; k <= 7; k++) begin
         push($sformatf("bsy_rel_en1_t%0d", k), SIG_EN, 4'b0010, (k < 7) ? 4'b0010 : 4'b0000);
         push($sformatf("bsy_rel_gated1_t%0d", k), SIG_GATED, 4'b0010, (k == 7) ? 4'b0010 : 4'b0000);
         push($sformatf("bsy_rel_ack1_t%0d", k), SIG_ACK, 4'b0010, 4'b0000);
         step();
      end

      // Overrides with everything OFF
      RST = 1'b1; req = 4'b0000;
      step();
      RST = 1'b0; force_on = 4'b0100;
      #1;
      push("frc_en", SIG_EN, 4'hF, 4'b0100);
      push("frc_gated", SIG_GATED, 4'hF, 4'hF);
      push("frc_ack", SIG_ACK, 4'hF, 4'h0);
      drain();
      test_mode = 1'b1;
      #1;
      push("tm_se_on", SIG_SE, 4'hF, 4'hF);
      drain();
      push("frc_en_hold", SIG_EN, 4'hF, 4'b0100);
      push("frc_gated_hold", SIG_GATED, 4'hF, 4'hF);
      step();
      req = 4'b0100;
      push("frc_wake_ack_c1", SIG_ACK, 4'b0100, 4'b0000);
      push("frc_wake_gated_c1", SIG_GATED, 4'b0100, 4'b0000);
      step();
      push("frc_wake_ack_c2", SIG_ACK, 4'b0100, 4'b0000);
      step();
      push("frc_wake_ack_c3", SIG_ACK, 4'b0100, 4'b0100);
      step();
      force_on = 4'b0000; test_mode = 1'b0;
      #1;
      push("tm_se_off", SIG_SE, 4'hF, 4'h0);
      push("frc_off_en", SIG_EN, 4'hF, 4'b0100);
      drain();

      // Reset mid-wake of domain 1, then domain 0 wins
      req = 4'b0110;
      push("mw_en", SIG_EN, 4'hF, 4'b0110);
      push("mw_ack", SIG_ACK, 4'hF, 4'b0100);
      step();
      RST = 1'b1;
      push("mw_rst_en", SIG_EN, 4'hF, 4'h0);
      push("mw_rst_ack", SIG_ACK, 4'hF, 4'h0);
      push("mw_rst_gated", SIG_GATED, 4'hF, 4'hF);
      step();
      RST = 1'b0; req = 4'b1111;
      push("post_rst_en", SIG_EN, 4'hF, 4'b0001);
      push("post_rst_gated", SIG_GATED, 4'hF, 4'b1110);
      step();
      step();
      push("post_rst_ack", SIG_ACK, 4'hF, 4'b0001);
      push("post_rst_en2", SIG_EN, 4'hF, 4'b0011);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
